// File: rtl/alu_seq_hs_if.sv
// Operand/result bus of alu_seq_hs: request side (in_*, a, b, op) and response side (out_*, result, flags).
// Both sides use valid/ready: a transfer happens on a rising edge where valid && ready; valid must hold its payload until then.
interface alu_seq_hs_if #(
   parameter int WIDTH = 32
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [3:0]       op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             sign;

   modport master (
      output in_valid, a, b, op, out_ready,
      input  in_ready, out_valid, result, carry, zero, sign
   );

   modport slave (
      input  in_valid, a, b, op, out_ready,
      output in_ready, out_valid, result, carry, zero, sign
   );
endinterface

// File: rtl/alu_seq_hs.sv
// Registered ALU with valid/ready handshake and iterative shifts (one bit per cycle).
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_seq_hs #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_seq_hs_if.slave bus,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, HOLD = 2'd2} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [1:0]       kind_q, kind_d;
   logic             in_ready;
   logic             accept;
   logic [SHW-1:0]   amt;

   assign amt      = bus.b[SHW-1:0];
   assign in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
   assign accept   = bus.in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
   // One guard bit on the far side of each shift catches the last bit shifted out.
   logic [WIDTH:0] sll_ext, srl_ext, sra_ext;
   assign sll_ext = {1'b0, bus.a} << amt;
   assign srl_ext = {bus.a, 1'b0} >> amt;
   assign sra_ext = $unsigned($signed({bus.a, 1'b0}) >>> amt);
`endif

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      kind_d   = kind_q;

      case (state_q)
         SHIFT: begin
            case (kind_q)
               2'b01: begin
                  carry_d  = result_q[WIDTH-1];
                  result_d = {result_q[WIDTH-2:0], 1'b0};
               end
               2'b10: begin
                  carry_d  = result_q[0];
                  result_d = {1'b0, result_q[WIDTH-1:1]};
               end
               default: begin
                  carry_d  = result_q[0];
                  result_d = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
               end
            endcase
            cnt_d = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) state_d = HOLD;
         end
         HOLD: begin
            if (bus.out_ready && !bus.in_valid) state_d = IDLE;
         end
         default: ;
      endcase

      // Accept is only possible from IDLE or a draining HOLD, so it never collides with SHIFT.
      if (accept) begin
         state_d = HOLD;
         carry_d = 1'b0;
         case (bus.op)
            4'd0: {carry_d, result_d} = {1'b0, bus.a} + {1'b0, bus.b};
            4'd1: {carry_d, result_d} = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
            4'd2: result_d = bus.a & bus.b;
            4'd3: result_d = bus.a | bus.b;
            4'd4: result_d = bus.a ^ bus.b;
`ifdef ALU_FAST_SHIFT_EN
            4'd5: {carry_d, result_d} = sll_ext;
            4'd6: {result_d, carry_d} = srl_ext;
            4'd7: {result_d, carry_d} = sra_ext;
`else
            4'd5, 4'd6, 4'd7: begin
               result_d = bus.a;
               if (amt != '0) begin
                  state_d = SHIFT;
                  cnt_d   = amt;
                  kind_d  = bus.op[1:0];
               end
            end
`endif
            default: result_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
         carry_q  <= 1'b0;
         cnt_q    <= '0;
         kind_q   <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         cnt_q    <= cnt_d;
         kind_q   <= kind_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state_q == HOLD);
   assign bus.result    = result_q;
   assign bus.carry     = carry_q;
   assign bus.zero      = (result_q == '0);
   assign bus.sign      = result_q[WIDTH-1];
   assign state_dbg     = state_q;

endmodule
